// File: rtl/stage_renderer.sv
// Frame-drawing engine: rasters the 11x11-tile playfield, then overlays a sprite
// for every live bomb slot, emitting one plot strobe per drawn pixel.
module stage_renderer #(
  parameter int ORIGIN_X = 72,
  parameter int ORIGIN_Y = 32,
  parameter int FIELD_PX = 176
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  map_tile_id,
  input  logic        has_explosion,
  input  logic [17:0] bomb_info,
  output logic [8:0]  X,
  output logic [7:0]  Y,
  output logic [2:0]  bomb_id,
  output logic [8:0]  vga_x,
  output logic [7:0]  vga_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, FIELD, BFETCH, BDRAW} state_t;

  localparam logic [7:0] LAST_PX = 8'(FIELD_PX - 1);

  state_t      state, state_n;
  logic [7:0]  px, px_n, py, py_n;
  logic [3:0]  u, u_n, v, v_n;
  logic [8:0]  bx, bx_n;
  logic [7:0]  by, by_n;
  logic [8:0]  x_n, vga_x_n;
  logic [7:0]  y_n, vga_y_n;
  logic [2:0]  bomb_id_n, colour_n;
  logic        plot_n, busy_n, done_n;
  logic        advance;

  always_comb begin
    state_n   = state;
    px_n      = px;
    py_n      = py;
    u_n       = u;
    v_n       = v;
    bx_n      = bx;
    by_n      = by;
    x_n       = X;
    y_n       = Y;
    bomb_id_n = bomb_id;
    vga_x_n   = vga_x;
    vga_y_n   = vga_y;
    colour_n  = colour;
    plot_n    = 1'b0;
    busy_n    = busy;
    done_n    = 1'b0;
    advance   = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = FIELD;
          x_n     = 9'(ORIGIN_X);
          y_n     = 8'(ORIGIN_Y);
          px_n    = 8'd0;
          py_n    = 8'd0;
          busy_n  = 1'b1;
        end
      end
      FIELD: begin
        // The stage block answers the query within the cycle, so capture now.
        vga_x_n = X;
        vga_y_n = Y;
        plot_n  = 1'b1;
        if (has_explosion) colour_n = 3'b100;
        else begin
          case (map_tile_id)
            4'd0:    colour_n = 3'b010;
            4'd1:    colour_n = 3'b111;
            4'd2:    colour_n = 3'b110;
            default: colour_n = 3'b011;
          endcase
        end
        if (px == LAST_PX) begin
          px_n = 8'd0;
          x_n  = 9'(ORIGIN_X);
          if (py == LAST_PX) begin
            state_n   = BFETCH;
            bomb_id_n = 3'd0;
          end else begin
            py_n = py + 8'd1;
            y_n  = Y + 8'd1;
          end
        end else begin
          px_n = px + 8'd1;
          x_n  = X + 9'd1;
        end
      end
      BFETCH: begin
        bx_n = bomb_info[9:1];
        by_n = bomb_info[17:10];
        if (bomb_info[0]) begin
          state_n = BDRAW;
          u_n     = 4'd0;
          v_n     = 4'd0;
        end else begin
          advance = 1'b1;
        end
      end
      BDRAW: begin
        // The sprite is a 12x12 square inset by two pixels in a 16x16 cell.
        vga_x_n  = bx + {5'd0, u};
        vga_y_n  = by + {4'd0, v};
        colour_n = 3'b000;
        plot_n   = (u >= 4'd2) && (u <= 4'd13) && (v >= 4'd2) && (v <= 4'd13);
        if (u == 4'd15) begin
          u_n = 4'd0;
          if (v == 4'd15) advance = 1'b1;
          else            v_n = v + 4'd1;
        end else begin
          u_n = u + 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (advance) begin
      if (bomb_id == 3'd5) begin
        state_n = IDLE;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        plot_n  = 1'b0;
      end else begin
        bomb_id_n = bomb_id + 3'd1;
        state_n   = BFETCH;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      px      <= 8'd0;
      py      <= 8'd0;
      u       <= 4'd0;
      v       <= 4'd0;
      bx      <= 9'd0;
      by      <= 8'd0;
      X       <= 9'd0;
      Y       <= 8'd0;
      bomb_id <= 3'd0;
      vga_x   <= 9'd0;
      vga_y   <= 8'd0;
      colour  <= 3'd0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      px      <= px_n;
      py      <= py_n;
      u       <= u_n;
      v       <= v_n;
      bx      <= bx_n;
      by      <= by_n;
      X       <= x_n;
      Y       <= y_n;
      bomb_id <= bomb_id_n;
      vga_x   <= vga_x_n;
      vga_y   <= vga_y_n;
      colour  <= colour_n;
      plot    <= plot_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

endmodule

// File: tb/tb_stage_renderer.sv
// Bench for stage_renderer: a stage/bomb model answers pixel queries, and each
// frame's plot stream is checked against a pixel list built from the drawing rules.
module tb_stage_renderer;

  typedef logic [19:0] pix_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  map_tile_id;
  logic        has_explosion;
  logic [17:0] bomb_info;
  logic [8:0]  X, vga_x;
  logic [7:0]  Y, vga_y;
  logic [2:0]  bomb_id, colour;
  logic        plot, busy, done;

  logic [3:0]  tile_map [11][11];
  logic        expl_map [11][11];
  logic [8:0]  slot_x [6];
  logic [7:0]  slot_y [6];
  logic        slot_en [6];

  pix_t obs[$];
  pix_t exp_q[$];
  int   pass_cnt = 0;
  int   check_cnt = 0;
  int   done_edge, done_cnt;

  stage_renderer #(.ORIGIN_X(72), .ORIGIN_Y(32), .FIELD_PX(176)) dut (
    .clk(clk), .resetn(resetn), .start(start), .map_tile_id(map_tile_id),
    .has_explosion(has_explosion), .bomb_info(bomb_info), .X(X), .Y(Y),
    .bomb_id(bomb_id), .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
    .plot(plot), .busy(busy), .done(done)
  );

  always #10 clk = ~clk;

  // Stage/bomb block model: answers the current query combinationally.
  always_comb begin
    int tx, ty;
    map_tile_id   = 4'd0;
    has_explosion = 1'b0;
    bomb_info     = 18'd0;
    tx = (int'(X) - 72) / 16;
    ty = (int'(Y) - 32) / 16;
    if (int'(X) >= 72 && int'(X) < 248 && int'(Y) >= 32 && int'(Y) < 208) begin
      map_tile_id   = tile_map[tx][ty];
      has_explosion = expl_map[tx][ty];
    end
    if (bomb_id < 3'd6) bomb_info = {slot_y[bomb_id], slot_x[bomb_id], slot_en[bomb_id]};
  end

  function automatic logic [2:0] field_colour(int tx, int ty);
    if (expl_map[tx][ty]) return 3'b100;
    case (tile_map[tx][ty])
      4'd0:    return 3'b010;
      4'd1:    return 3'b111;
      4'd2:    return 3'b110;
      default: return 3'b011;
    endcase
  endfunction

  function automatic int build_expected();
    int enabled = 0;
    exp_q.delete();
    for (int y = 0; y < 176; y++)
      for (int x = 0; x < 176; x++)
        exp_q.push_back({9'(72 + x), 8'(32 + y), field_colour(x / 16, y / 16)});
    for (int s = 0; s < 6; s++) begin
      if (slot_en[s]) begin
        enabled++;
        for (int v = 0; v < 16; v++)
          for (int u = 0; u < 16; u++)
            if (u >= 2 && u <= 13 && v >= 2 && v <= 13)
              exp_q.push_back({9'(int'(slot_x[s]) + u), 8'(int'(slot_y[s]) + v), 3'b000});
      end
    end
    return 30982 + 256 * enabled;
  endfunction

  function automatic int stream_errors();
    int bad = 0;
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++)
      if (obs[i] !== exp_q[i]) bad++;
    return bad;
  endfunction

  function automatic pix_t obs_at(int idx);
    if (idx < obs.size()) return obs[idx];
    return '1;
  endfunction

  task automatic clear_stage();
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) begin
        tile_map[i][j] = 4'd0;
        expl_map[i][j] = 1'b0;
      end
    for (int s = 0; s < 6; s++) begin
      slot_x[s]  = 9'd0;
      slot_y[s]  = 8'd0;
      slot_en[s] = 1'b0;
    end
  endtask

  // Edge 0 samples start; edge e is sampled #1 after it. Stops 20 edges past done.
  task automatic run_frame(input int start_again_at);
    obs.delete();
    done_edge = -1;
    done_cnt  = 0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int e = 1; e <= 40000; e++) begin
      if (e == start_again_at) start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      if (plot === 1'b1) obs.push_back({vga_x, vga_y, colour});
      if (done === 1'b1) begin
        done_cnt++;
        if (done_edge < 0) done_edge = e;
      end
      if (done_edge >= 0 && e >= done_edge + 20) break;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_stage();
    #5;
    check_cnt++;
    if ({X, Y, vga_x, vga_y, colour, plot, busy, done, bomb_id} !== 47'd0) begin
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {X, Y, vga_x, vga_y, colour, plot, busy, done, bomb_id});
    end else pass_cnt++;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (1000) @(posedge clk);
    #1;
    check_cnt++;
    if ({plot, busy} !== 2'b11) $display("[TB] FAIL mid_frame_active: plot,busy=%b expected 11", {plot, busy});
    else pass_cnt++;
    resetn = 1'b0;
    #1;
    check_cnt++;
    if ({plot, busy, done, X, Y} !== 20'd0)
      $display("[TB] FAIL mid_frame_reset: plot=%b busy=%b done=%b X=%0d Y=%0d expected all 0",
               plot, busy, done, X, Y);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_plain_frame_ignored_start();
    int exp_done;
    clear_stage();
    exp_done = build_expected();
    run_frame(500);
    check_cnt++;
    if (obs.size() !== 30976) $display("[TB] FAIL plain_plot_count: got %0d expected 30976", obs.size());
    else pass_cnt++;
    check_cnt++;
    if (stream_errors() !== 0) $display("[TB] FAIL plain_stream: %0d wrong pixels expected 0", stream_errors());
    else pass_cnt++;
    check_cnt++;
    if (obs_at(0) !== {9'd72, 8'd32, 3'b010}) $display("[TB] FAIL plain_first: got %h expected %h", obs_at(0), {9'd72, 8'd32, 3'b010});
    else pass_cnt++;
    check_cnt++;
    if (obs_at(30975) !== {9'd247, 8'd207, 3'b010}) $display("[TB] FAIL plain_last: got %h expected %h", obs_at(30975), {9'd247, 8'd207, 3'b010});
    else pass_cnt++;
    check_cnt++;
    if (done_edge !== exp_done) $display("[TB] FAIL plain_done_edge: got %0d expected %0d", done_edge, exp_done);
    else pass_cnt++;
    check_cnt++;
    if (done_cnt !== 1) $display("[TB] FAIL plain_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("[TB] FAIL plain_busy_after: got %b expected 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_tiles_and_bomb();
    int exp_done, minx, maxx, miny, maxy, blacks;
    pix_t p;
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) begin
        tile_map[i][j] = 4'($urandom_range(0, 15));
        expl_map[i][j] = ($urandom_range(0, 7) == 0);
      end
    tile_map[3][4] = 4'd1;
    expl_map[3][4] = 1'b0;
    expl_map[5][5] = 1'b1;
    for (int s = 0; s < 6; s++) begin
      slot_x[s]  = 9'($urandom_range(0, 232));
      slot_y[s]  = 8'($urandom_range(0, 192));
      slot_en[s] = 1'b0;
    end
    slot_x[2]  = 9'd104;
    slot_y[2]  = 8'd48;
    slot_en[2] = 1'b1;
    exp_done = build_expected();
    run_frame(0);
    check_cnt++;
    if (obs.size() !== 31120) $display("[TB] FAIL tb_plot_count: got %0d expected 31120", obs.size());
    else pass_cnt++;
    check_cnt++;
    if (stream_errors() !== 0) $display("[TB] FAIL tb_stream: %0d wrong pixels expected 0", stream_errors());
    else pass_cnt++;
    check_cnt++;
    if (done_edge !== 31238) $display("[TB] FAIL tb_done_edge: got %0d expected 31238 (model %0d)", done_edge, exp_done);
    else pass_cnt++;
    check_cnt++;
    if ({obs_at(64 * 176 + 48), obs_at(79 * 176 + 63)} !== {9'd120, 8'd96, 3'b111, 9'd135, 8'd111, 3'b111})
      $display("[TB] FAIL tile1_corners: got %h %h expected colour 111", obs_at(64 * 176 + 48), obs_at(79 * 176 + 63));
    else pass_cnt++;
    check_cnt++;
    if ({obs_at(80 * 176 + 80), obs_at(95 * 176 + 95)} !== {9'd152, 8'd112, 3'b100, 9'd167, 8'd127, 3'b100})
      $display("[TB] FAIL explosion_corners: got %h %h expected colour 100", obs_at(80 * 176 + 80), obs_at(95 * 176 + 95));
    else pass_cnt++;
    minx = 999; maxx = -1; miny = 999; maxy = -1; blacks = 0;
    for (int i = 30976; i < obs.size(); i++) begin
      p = obs[i];
      if (p[2:0] == 3'b000) blacks++;
      if (int'(p[19:11]) < minx) minx = int'(p[19:11]);
      if (int'(p[19:11]) > maxx) maxx = int'(p[19:11]);
      if (int'(p[10:3]) < miny) miny = int'(p[10:3]);
      if (int'(p[10:3]) > maxy) maxy = int'(p[10:3]);
    end
    check_cnt++;
    if (blacks !== 144) $display("[TB] FAIL bomb_black_plots: got %0d expected 144", blacks);
    else pass_cnt++;
    check_cnt++;
    if ({minx, maxx, miny, maxy} !== {32'd106, 32'd117, 32'd50, 32'd61})
      $display("[TB] FAIL bomb_extent: got x %0d..%0d y %0d..%0d expected x 106..117 y 50..61", minx, maxx, miny, maxy);
    else pass_cnt++;
    check_cnt++;
    if (done_cnt !== 1) $display("[TB] FAIL tb_done_count: got %0d expected 1", done_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_plain_frame_ignored_start();
    test_tiles_and_bomb();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
